if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register. It directly consumes pcwrite/ifid_write/ifid_flush and the branch redirect from the ID-stage hazard detection unit.
- Owns the PC, issues requests to a variable-latency instruction memory, and presents {PC+4, instruction, valid} to the ID stage.
- A branch redirect that arrives while a fetch is outstanding is handled by letting that fetch finish and discarding it.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ifid_reg.sv | 40 ++++
 rtl/if_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types and defaults for the fetch front end.
package cpu_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} if_state_t;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  // IF/ID layout for the default 32-bit PC build.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with flush > hold > load > bubble priority.
module ifid_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            write_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] pc4_i,
  input  logic [31:0]     instr_i,
  output logic [PC_W-1:0] pc4_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc4_o   <= '0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      pc4_o   <= '0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (!write_i) begin
      pc4_o   <= pc4_o;
      instr_o <= instr_o;
      valid_o <= valid_o;
    end else if (load_i) begin
      pc4_o   <= pc4_i;
      instr_o <= instr_i;
      valid_o <= 1'b1;
    end else begin
      pc4_o   <= '0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem handshake FSM, IF/ID register.
// Optional perf counters under IF_STAGE_PERF_CNT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pcwrite_i,
  input  logic            ifid_write_i,
  input  logic            ifid_flush_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] ifid_pc4_o,
  output logic [31:0]     ifid_instr_o,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_flush_cnt_o,
`endif
  output logic            ifid_valid_o
);
  if_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, redir_q, redir_d, pc4;
  logic            fetch_done, ifid_load, ifid_bubble;

  assign pc4         = pc_q + PC_W'(4);
  assign pc_o        = pc_q;
  assign imem_req_o  = ~rst_i;
  // PC never moves while a request is outstanding, so the address is always pc_q.
  assign imem_addr_o = pc_q;
  assign fetch_done  = imem_ready_i && (state_q != DROP);
  assign ifid_load   = fetch_done && pcwrite_i;
  assign ifid_bubble = ifid_flush_i || branch_i;

  // A branch arriving while the current request is still pending (FETCH or
  // WAIT, not ready) parks in DROP so the address stays stable until ready.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      FETCH, WAIT: begin
        if (imem_ready_i) begin
          state_d = FETCH;
          if (branch_i)       pc_d = branch_target_i;
          else if (pcwrite_i) pc_d = pc4;
        end else if (branch_i) begin
          state_d = DROP;
          redir_d = branch_target_i;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        if (branch_i) redir_d = branch_target_i;
        if (imem_ready_i) begin
          state_d = FETCH;
          pc_d    = branch_i ? branch_target_i : redir_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  ifid_reg #(.PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .write_i (ifid_write_i),
    .flush_i (ifid_bubble),
    .load_i  (ifid_load),
    .pc4_i   (pc4),
    .instr_i (imem_rdata_i),
    .pc4_o   (ifid_pc4_o),
    .instr_o (ifid_instr_o),
    .valid_o (ifid_valid_o)
  );

`ifdef IF_STAGE_PERF_CNT_EN
  logic fetch_inc;
  assign fetch_inc = ifid_load && ifid_write_i && !ifid_bubble;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (fetch_inc && perf_fetch_cnt_o != '1)     perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (!imem_ready_i && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (ifid_bubble && perf_flush_cnt_o != '1)   perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif
endmodule
